draw_scheduler: RTL and testbench
=================================

Name: draw_scheduler

Overview:
- Sequences all framebuffer writes for the game display and is the single owner of the VGA adapter pixel-write port.
- On each frame tick it erases the block at its previous position, then draws it at its current position, taking x, prev_x, y and game_status from the game logic top.
- On game_status changes it clears the full screen.
- It sits between the game logic top and the VGA adapter.

Parameters:
BLOCK_W, 16, block width in pixels
BLOCK_H, 4, block height in pixels
SCREEN_W, 160, screen width in pixels
SCREEN_H, 120, screen height in pixels
BG_COLOUR, 3'b000, background / erase colour
BLOCK_COLOUR, 3'b110, moving block colour
OVER_COLOUR, 3'b100, game-over fill colour

Ports:
clk  in  1  50MHz clock
resetn  in  1  asynchronous active-low reset
sync  in  1  frame tick, one-cycle pulse from delay counter
x  in  8  current block x
prev_x  in  8  previous block x
y  in  7  current block y
game_status  in  2  00 READY, 01 PLAYING, 10 OVER, 11 treated as READY
vga_x  out  8  pixel x to adapter
vga_y  out  7  pixel y to adapter
colour  out  3  pixel colour
plot  out  1  pixel write strobe
busy  out  1  sequence in progress
overrun  out  1  sticky: sync arrived while busy

Behaviour:
- Reset: asynchronous, active-low, any state. vga_x=0, vga_y=0, colour=0, plot=0, busy=0, overrun=0. Snapshot registers = 0. last_status = READY. State = INIT.
- States: INIT, IDLE, ERASE, DRAW, CLEAR.
- INIT: on the first clock edge after reset release, load CLEAR with BG_COLOUR and set busy=1.
- IDLE, clear pending: a pending clear takes priority over sync.
  - Pending OVER clear enters CLEAR with OVER_COLOUR.
  - Pending READY clear enters CLEAR with BG_COLOUR.
- IDLE, sync=1 and game_status=PLAYING:
  - At the same edge, snapshot x, prev_x and y, set busy=1.
  - Go to ERASE, or directly to DRAW if prev_x==x.
- IDLE, sync=1 and status not PLAYING: ignored; no flag set.
- ERASE: raster the BLOCK_W x BLOCK_H rectangle at (prev_x_s, y_s) in BG_COLOUR.
  - Row-major order; px is the inner counter, py the outer.
  - One pixel per cycle; the DRAW state follows.
- DRAW: same raster at (x_s, y_s) in BLOCK_COLOUR, then return to IDLE.
- CLEAR: raster the full SCREEN_W x SCREEN_H area at origin (0,0), then return to IDLE.
- Output timing: outputs are registered. The pixel for counter value (px,py) appears on vga_x/vga_y/colour/plot one cycle after the counter holds it. Plot pulses are contiguous within a sequence, with no gap between ERASE and DRAW.
- busy: deasserts on the edge after the last pixel is presented.
- Arithmetic: pixel x = base_x + px and pixel y = base_y + py, each computed one bit wider.
  - If the pixel x result is >= SCREEN_W, or the pixel y result is >= SCREEN_H, plot=0 for that cycle.
  - The counter still advances, so sequence length is fixed at BLOCK_W*BLOCK_H cycles.
- Status edge detect: each cycle compare game_status against last_status, then update last_status.
  - Change into OVER sets clear_pend=OVER.
  - Change into READY or 11 sets clear_pend=READY.
  - Change into PLAYING sets no clear.
  - The latest change overwrites an earlier pending one.
- Mid-sequence status change: the edge is latched only. It is serviced when the current ERASE/DRAW/CLEAR completes, before any later sync.
- overrun: set when sync=1 while busy=1. The sync is dropped, never queued. Cleared only by reset.
- Inputs changing during ERASE/DRAW have no effect; the snapshot is used.
- Reset mid-sequence: plot drops immediately, and the sequence restarts from INIT.

Decomposition:
- Package draw_pkg holds:
  - game status encodings (STATUS_READY, STATUS_PLAYING, STATUS_OVER)
  - the state enum
  - default colour constants
- One sub-module, rect_scanner:
  - Inputs: start, width, height.
  - Outputs: px, py, active, last.
  - px/py counters with active and a last-pixel pulse.
  - Shared by ERASE, DRAW and CLEAR with width/height selected per state.

Test Plan:
- Release reset -> 19200 contiguous plot pulses with colour 000 covering (0,0)..(159,119) -> busy=0, overrun=0.
- game_status=01, sync with x=40, prev_x=32, y=100 -> 64 plots colour 000 at x 32..47, y 100..103, then 64 plots colour 110 at x 40..55 -> busy low after 128 pixels.
- sync with x=prev_x=60, y=20 -> ERASE skipped; exactly 64 plots colour 110 at x 60..75.
- sync with x=150, prev_x=150, y=118 -> 64 DRAW cycles, plot high only for x 150..159, y 118..119 (20 pulses).
- Second sync 10 cycles into a DRAW -> ignored, overrun=1, sticky until reset; pixel stream unchanged.
- game_status 01->10 during DRAW -> DRAW completes, then 19200 plots colour 100; a sync during the clear sets overrun.

Source files
------------

// File: rtl/draw_pkg.sv
// draw_pkg: shared definitions for the draw scheduler.
//   - game status encodings driven by the game logic top
//   - scheduler state encoding (also exported on the debug state port)
//   - default geometry and colour constants used as parameter defaults
package draw_pkg;

  localparam logic [1:0] STATUS_READY   = 2'b00;
  localparam logic [1:0] STATUS_PLAYING = 2'b01;
  localparam logic [1:0] STATUS_OVER    = 2'b10;

  localparam int DEF_BLOCK_W  = 16;
  localparam int DEF_BLOCK_H  = 4;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  localparam logic [2:0] DEF_BG_COLOUR    = 3'b000;
  localparam logic [2:0] DEF_BLOCK_COLOUR = 3'b110;
  localparam logic [2:0] DEF_OVER_COLOUR  = 3'b100;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ERASE,
    ST_DRAW,
    ST_CLEAR
  } draw_state_t;

endpackage

// File: rtl/rect_scanner.sv
// rect_scanner: row-major rectangle walker, one position per cycle.
// Ports:
//   clk, resetn    clock, asynchronous active-low reset
//   start          restart at (0,0) and run; wins over normal advance,
//                  so a start on the last position chains seamlessly
//   width, height  rectangle size, sampled every cycle while active
//   px, py         current position (px inner, py outer)
//   active         a position is held in px/py this cycle
//   last           combinational: current position is the final one
module rect_scanner (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] width,
  input  logic [6:0] height,
  output logic [7:0] px,
  output logic [6:0] py,
  output logic       active,
  output logic       last
);

  logic px_end;
  logic py_end;

  assign px_end = (px == width - 8'd1);
  assign py_end = (py == height - 7'd1);
  assign last   = active && px_end && py_end;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      px     <= 8'd0;
      py     <= 7'd0;
      active <= 1'b0;
    end else if (start) begin
      px     <= 8'd0;
      py     <= 7'd0;
      active <= 1'b1;
    end else if (active) begin
      if (px_end) begin
        px <= 8'd0;
        if (py_end) begin
          active <= 1'b0;
        end else begin
          py <= py + 7'd1;
        end
      end else begin
        px <= px + 8'd1;
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// draw_scheduler: sole owner of the VGA adapter pixel-write port.
// Per frame tick it erases the block at its previous x and draws it at the
// current x; on game_status changes it fills the whole screen.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   sync               frame tick (one-cycle pulse)
//   x, prev_x, y       block position from game logic (snapshotted on sync)
//   game_status        00 READY, 01 PLAYING, 10 OVER, 11 as READY
//   vga_x, vga_y       registered pixel coordinate to the adapter
//   colour, plot       registered pixel colour and write strobe
//   busy               a raster sequence is in progress
//   overrun            sticky: a sync arrived while busy (reset clears it)
//   state              current scheduler state, for observation
// Handshake: sync is a request with no back-pressure. It is accepted only
// when state is IDLE, busy is low, no clear is pending and the game is
// PLAYING; a sync seen while busy is dropped and recorded in overrun.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int         BLOCK_W      = DEF_BLOCK_W,
  parameter int         BLOCK_H      = DEF_BLOCK_H,
  parameter int         SCREEN_W     = DEF_SCREEN_W,
  parameter int         SCREEN_H     = DEF_SCREEN_H,
  parameter logic [2:0] BG_COLOUR    = DEF_BG_COLOUR,
  parameter logic [2:0] BLOCK_COLOUR = DEF_BLOCK_COLOUR,
  parameter logic [2:0] OVER_COLOUR  = DEF_OVER_COLOUR
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sync,
  input  logic [7:0]  x,
  input  logic [7:0]  prev_x,
  input  logic [6:0]  y,
  input  logic [1:0]  game_status,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        overrun,
  output draw_state_t state
);

  draw_state_t state_next;

  logic [7:0] x_s;
  logic [7:0] prev_x_s;
  logic [6:0] y_s;
  logic [1:0] last_status;
  logic       clear_pend;
  logic       clear_over;
  logic [2:0] fill_colour;
  logic [2:0] fill_next;

  logic       scan_start;
  logic       load_snap;
  logic       clear_take;

  logic [7:0] px;
  logic [6:0] py;
  logic       active;
  logic       last;
  logic [7:0] scan_w;
  logic [6:0] scan_h;

  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] pix_colour;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       in_screen;
  logic       scanning;
  logic       status_changed;

  // Block and full-screen sizes share one scanner; the size follows the
  // state, which always changes on the same edge as a scanner start.
  assign scan_w = (state == ST_CLEAR) ? 8'(SCREEN_W) : 8'(BLOCK_W);
  assign scan_h = (state == ST_CLEAR) ? 7'(SCREEN_H) : 7'(BLOCK_H);

  rect_scanner u_scanner (
    .clk    (clk),
    .resetn (resetn),
    .start  (scan_start),
    .width  (scan_w),
    .height (scan_h),
    .px     (px),
    .py     (py),
    .active (active),
    .last   (last)
  );

  // Next-state and control.
  always_comb begin
    state_next = state;
    scan_start = 1'b0;
    load_snap  = 1'b0;
    clear_take = 1'b0;
    fill_next  = fill_colour;
    case (state)
      ST_INIT: begin
        state_next = ST_CLEAR;
        scan_start = 1'b1;
        fill_next  = BG_COLOUR;
      end
      ST_IDLE: begin
        if (clear_pend) begin
          state_next = ST_CLEAR;
          scan_start = 1'b1;
          clear_take = 1'b1;
          fill_next  = clear_over ? OVER_COLOUR : BG_COLOUR;
        end else if (sync && !busy && game_status == STATUS_PLAYING) begin
          state_next = (prev_x == x) ? ST_DRAW : ST_ERASE;
          scan_start = 1'b1;
          load_snap  = 1'b1;
        end
      end
      ST_ERASE: begin
        if (last) begin
          state_next = ST_DRAW;
          scan_start = 1'b1;
        end
      end
      ST_DRAW: begin
        if (last) state_next = ST_IDLE;
      end
      ST_CLEAR: begin
        if (last) state_next = ST_IDLE;
      end
      default: state_next = ST_INIT;
    endcase
  end

  // Pixel address and colour for the current scanner position.
  always_comb begin
    base_x     = 8'd0;
    base_y     = 7'd0;
    pix_colour = fill_colour;
    case (state)
      ST_ERASE: begin
        base_x     = prev_x_s;
        base_y     = y_s;
        pix_colour = BG_COLOUR;
      end
      ST_DRAW: begin
        base_x     = x_s;
        base_y     = y_s;
        pix_colour = BLOCK_COLOUR;
      end
      default: ;
    endcase
  end

  // One bit wider so a block hanging off the right/bottom edge is detected
  // and suppressed instead of wrapping onto the opposite side.
  assign sum_x     = {1'b0, base_x} + {1'b0, px};
  assign sum_y     = {1'b0, base_y} + {1'b0, py};
  assign in_screen = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
  assign scanning  = active &&
                     (state == ST_ERASE || state == ST_DRAW || state == ST_CLEAR);

  assign status_changed = (game_status != last_status);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_INIT;
      x_s         <= 8'd0;
      prev_x_s    <= 8'd0;
      y_s         <= 7'd0;
      last_status <= STATUS_READY;
      clear_pend  <= 1'b0;
      clear_over  <= 1'b0;
      fill_colour <= BG_COLOUR;
      vga_x       <= 8'd0;
      vga_y       <= 7'd0;
      colour      <= 3'b000;
      plot        <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_next;
      fill_colour <= fill_next;
      last_status <= game_status;

      if (load_snap) begin
        x_s      <= x;
        prev_x_s <= prev_x;
        y_s      <= y;
      end

      // A fresh status edge outranks consuming the pending one, so the
      // newest change is never lost.
      if (status_changed && game_status != STATUS_PLAYING) begin
        clear_pend <= 1'b1;
        clear_over <= (game_status == STATUS_OVER);
      end else if (status_changed) begin
        clear_pend <= clear_pend && !clear_take;
      end else if (clear_take) begin
        clear_pend <= 1'b0;
      end

      plot <= scanning && in_screen;
      if (scanning) begin
        vga_x  <= sum_x[7:0];
        vga_y  <= sum_y[6:0];
        colour <= pix_colour;
      end

      // Stays high through the cycle that presents the final pixel.
      busy <= (state_next != ST_IDLE) || (state != ST_IDLE);

      if (sync && busy) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
module tb_draw_scheduler;
  import draw_pkg::*;

  localparam int BUDGET = 40000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sync = 1'b0;
  logic [7:0]  x = 8'd0;
  logic [7:0]  prev_x = 8'd0;
  logic [6:0]  y = 7'd0;
  logic [1:0]  game_status = STATUS_READY;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        overrun;
  draw_state_t state;

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  int cyc = 0;
  int plot_first = 0;
  int plot_last = 0;
  int n_busy;

  // ---------------- clock / reset ----------------
  always #10 clk = ~clk;

  draw_scheduler dut (
    .clk         (clk),
    .resetn      (resetn),
    .sync        (sync),
    .x           (x),
    .prev_x      (prev_x),
    .y           (y),
    .game_status (game_status),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .overrun     (overrun),
    .state       (state)
  );

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (plot) begin
      if (obs_q.size() == 0) plot_first = cyc;
      plot_last = cyc;
      obs_q.push_back({vga_x, vga_y, colour});
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic begin_seq();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic expect_rect(input int bx, input int by, input int w, input int h,
                             input logic [2:0] col);
    for (int ry = 0; ry < h; ry++) begin
      for (int rx = 0; rx < w; rx++) begin
        if (bx + rx < 160 && by + ry < 120)
          exp_q.push_back({8'(bx + rx), 7'(by + ry), col});
      end
    end
  endtask

  task automatic end_seq(input string tag, input logic contiguous);
    int mism;
    int n;
    mism = 0;
    n = obs_q.size();
    check({tag, "_count"}, n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) mism++;
    check({tag, "_pixels"}, mism, 0);
    if (contiguous) check({tag, "_contig"}, plot_last - plot_first + 1, n);
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_sync(input logic [7:0] nx, input logic [7:0] npx, input logic [6:0] ny);
    @(negedge clk);
    x = nx;
    prev_x = npx;
    y = ny;
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  // Counts negedge samples with busy high; bounded by BUDGET.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < BUDGET) begin
      n++;
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #25;
    check("rst_vga_x", vga_x, 0);
    check("rst_vga_y", vga_y, 0);
    check("rst_colour", colour, 0);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", state, ST_INIT);

    // Power-up clear.
    begin_seq();
    expect_rect(0, 0, 160, 120, 3'b000);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    wait_idle(n_busy);
    check("init_busy_cycles", n_busy, 19201);
    end_seq("init_clear", 1'b1);
    check("init_overrun", overrun, 0);

    // Entering PLAYING does not clear.
    game_status = STATUS_PLAYING;
    repeat (4) @(negedge clk);
    check("to_playing_no_clear", busy, 0);

    // Erase then draw.
    begin_seq();
    expect_rect(32, 100, 16, 4, 3'b000);
    expect_rect(40, 100, 16, 4, 3'b110);
    pulse_sync(8'd40, 8'd32, 7'd100);
    wait_idle(n_busy);
    check("ed_busy_cycles", n_busy, 129);
    end_seq("erase_draw", 1'b1);

    // Same x: erase skipped.
    repeat (3) @(negedge clk);
    begin_seq();
    expect_rect(60, 20, 16, 4, 3'b110);
    pulse_sync(8'd60, 8'd60, 7'd20);
    wait_idle(n_busy);
    check("skip_busy_cycles", n_busy, 65);
    end_seq("skip_erase", 1'b1);

    // Clipping at the bottom-right corner: 10 x 2 visible pixels.
    repeat (3) @(negedge clk);
    begin_seq();
    expect_rect(150, 118, 16, 4, 3'b110);
    pulse_sync(8'd150, 8'd150, 7'd118);
    wait_idle(n_busy);
    check("clip_busy_cycles", n_busy, 65);
    end_seq("clip", 1'b0);
    check("clip_overrun", overrun, 0);

    // Sync during DRAW is dropped; changed inputs are ignored.
    repeat (3) @(negedge clk);
    begin_seq();
    expect_rect(70, 50, 16, 4, 3'b110);
    pulse_sync(8'd70, 8'd70, 7'd50);
    repeat (9) @(negedge clk);
    x = 8'd0;
    prev_x = 8'd5;
    y = 7'd3;
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    wait_idle(n_busy);
    check("ovr_busy_tail", n_busy, 55);
    end_seq("overrun_draw", 1'b1);
    check("overrun_set", overrun, 1);
    repeat (20) @(negedge clk);
    check("overrun_sticky", overrun, 1);
    check("overrun_idle", busy, 0);

    // Reset in the middle of a sequence.
    pulse_sync(8'd20, 8'd20, 7'd5);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midrst_plot", plot, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_state", state, ST_INIT);
    begin_seq();
    expect_rect(0, 0, 160, 120, 3'b000);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    wait_idle(n_busy);
    check("rerst_busy_cycles", n_busy, 19201);
    end_seq("rerst_clear", 1'b1);

    // PLAYING -> OVER during DRAW, then a sync during the OVER clear.
    repeat (3) @(negedge clk);
    begin_seq();
    expect_rect(10, 10, 16, 4, 3'b110);
    expect_rect(0, 0, 160, 120, 3'b100);
    pulse_sync(8'd10, 8'd10, 7'd10);
    fork
      wait_idle(n_busy);
      begin
        repeat (5) @(negedge clk);
        game_status = STATUS_OVER;
        repeat (200) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
      end
    join
    check("over_busy_cycles", n_busy, 19266);
    end_seq("over_clear", 1'b0);
    check("over_overrun", overrun, 1);
    check("over_final_state", state, ST_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
